// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stores the alarm time, rings on a minute-change match,
// supports snooze and automatic ring timeout, and drives a square-wave buzzer.
module alarm_ctrl #(
   parameter int SNOOZE_MIN = 9,
   parameter int RING_MIN   = 5,
   parameter int BEEP_HALF  = 500
) (
   input  logic       clkMSec,
   input  logic       reset,
   input  logic [4:0] hour,
   input  logic [5:0] min,
   input  logic       changeMin,
   input  logic       alarmEn,
   input  logic       btnHour,
   input  logic       btnMin,
   input  logic       snooze,
   output logic [4:0] alarmHour,
   output logic [5:0] alarmMin,
   output logic       ringing,
   output logic       snoozed,
   output logic       buzzer
);

   localparam int BW = $clog2(BEEP_HALF);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   state_t          state;
   logic            change_d;
   logic [5:0]      ring_cnt;
   logic [5:0]      snz_cnt;
   logic [BW-1:0]   beep_cnt;
   logic [6:0]      ring_nxt;
   logic [6:0]      snz_nxt;
   logic            trigger;

   // hour/min only reflect the new minute one cycle after changeMin
   assign trigger  = change_d && (hour == alarmHour) && (min == alarmMin) && alarmEn;
   assign ring_nxt = {1'b0, ring_cnt} + 7'd1;
   assign snz_nxt  = {1'b0, snz_cnt} + 7'd1;

   always_ff @(posedge clkMSec) begin
      if (reset) begin
         state     <= IDLE;
         change_d  <= 1'b0;
         alarmHour <= '0;
         alarmMin  <= '0;
         ringing   <= 1'b0;
         snoozed   <= 1'b0;
         buzzer    <= 1'b0;
         ring_cnt  <= '0;
         snz_cnt   <= '0;
         beep_cnt  <= '0;
      end else begin
         change_d <= changeMin;
         case (state)
            IDLE: begin
               if (btnHour) alarmHour <= (alarmHour == 5'd23) ? 5'd0 : alarmHour + 5'd1;
               if (btnMin)  alarmMin  <= (alarmMin == 6'd59) ? 6'd0 : alarmMin + 6'd1;
               if (trigger) begin
                  state    <= RING;
                  ringing  <= 1'b1;
                  snoozed  <= 1'b0;
                  buzzer   <= 1'b1;
                  ring_cnt <= '0;
                  beep_cnt <= '0;
               end
            end
            RING: begin
               if (!alarmEn) begin
                  state   <= IDLE;
                  ringing <= 1'b0;
                  snoozed <= 1'b0;
                  buzzer  <= 1'b0;
               end else if (snooze) begin
                  state   <= SNOOZE;
                  ringing <= 1'b0;
                  snoozed <= 1'b1;
                  buzzer  <= 1'b0;
                  snz_cnt <= '0;
               end else if (changeMin && ring_nxt == 7'(RING_MIN)) begin
                  state   <= IDLE;
                  ringing <= 1'b0;
                  buzzer  <= 1'b0;
               end else begin
                  if (changeMin) ring_cnt <= ring_nxt[5:0];
                  if (beep_cnt == BW'(BEEP_HALF - 1)) begin
                     beep_cnt <= '0;
                     buzzer   <= ~buzzer;
                  end else begin
                     beep_cnt <= beep_cnt + 1'b1;
                  end
               end
            end
            SNOOZE: begin
               if (!alarmEn) begin
                  state   <= IDLE;
                  ringing <= 1'b0;
                  snoozed <= 1'b0;
                  buzzer  <= 1'b0;
               end else if (changeMin) begin
                  if (snz_nxt == 7'(SNOOZE_MIN)) begin
                     state    <= RING;
                     ringing  <= 1'b1;
                     snoozed  <= 1'b0;
                     buzzer   <= 1'b1;
                     ring_cnt <= '0;
                     beep_cnt <= '0;
                  end else begin
                     snz_cnt <= snz_nxt[5:0];
                  end
               end
            end
            default: begin
               state   <= IDLE;
               ringing <= 1'b0;
               snoozed <= 1'b0;
               buzzer  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expected outputs are queued as stimulus is
// driven and popped for comparison once the DUT has clocked that stimulus.
module tb_alarm_ctrl;

   localparam int BEEP = 500;

   typedef struct packed {
      logic [4:0] ah;
      logic [5:0] am;
      logic       r;
      logic       s;
      logic       b;
   } obs_t;

   logic       clkMSec = 1'b0;
   logic       reset, changeMin, alarmEn, btnHour, btnMin, snooze;
   logic [4:0] hour;
   logic [5:0] min;
   logic [4:0] alarmHour;
   logic [5:0] alarmMin;
   logic       ringing, snoozed, buzzer;

   obs_t       obs;
   obs_t       q[$];
   obs_t       e;
   int         checks = 0;
   int         errors = 0;

   logic [4:0] m_ah;
   logic [5:0] m_am;
   logic       m_ring, m_snz;
   int         m_age;

   alarm_ctrl dut (
      .clkMSec(clkMSec), .reset(reset), .hour(hour), .min(min),
      .changeMin(changeMin), .alarmEn(alarmEn), .btnHour(btnHour),
      .btnMin(btnMin), .snooze(snooze), .alarmHour(alarmHour),
      .alarmMin(alarmMin), .ringing(ringing), .snoozed(snoozed), .buzzer(buzzer)
   );

   always #5 clkMSec = ~clkMSec;

   assign obs = {alarmHour, alarmMin, ringing, snoozed, buzzer};

   function automatic obs_t model();
      logic buz;
      buz = m_ring && (((m_age / BEEP) % 2) == 0);
      return {m_ah, m_am, m_ring, m_snz, buz};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clkMSec);
         #1;
      end
   endtask

   // Walk the clock from 07:29 to 07:30 so the armed alarm fires.
   task automatic ring_up();
      hour = 5'd7; min = 6'd29;
      cyc(1);
      changeMin = 1'b1;
      cyc(1);
      changeMin = 1'b0; min = 6'd30;
      cyc(1);
      m_ring = 1'b1; m_snz = 1'b0; m_age = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m_ah = '0; m_am = '0; m_ring = 1'b0; m_snz = 1'b0; m_age = 0;
      q.push_back(model());
      cyc(2);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, e); end
      reset = 1'b0;
   endtask

   task automatic test_buttons();
      int sel[7] = '{0, 1, 0, 1, 1, 1, 0};
      int cnt[7] = '{7, 30, 17, 29, 1, 30, 7};
      alarmEn = 1'b1; hour = 5'd7; min = 6'd30;  // edits crossing 07:30 must not ring
      for (int g = 0; g < 7; g++) begin
         for (int k = 0; k < cnt[g]; k++) begin
            if (sel[g] == 0) begin
               btnHour = 1'b1; m_ah = 5'((int'(m_ah) + 1) % 24);
            end else begin
               btnMin = 1'b1;  m_am = 6'((int'(m_am) + 1) % 60);
            end
            q.push_back(model());
            cyc(1);
            btnHour = 1'b0; btnMin = 1'b0;
            e = q.pop_front(); checks++;
            if (obs !== e) begin
               errors++; $display("FAIL button g%0d k%0d obs=%h exp=%h", g, k, obs, e);
            end
         end
      end
   endtask

   task automatic test_ring();
      hour = 5'd7; min = 6'd29;
      cyc(1);
      changeMin = 1'b1;
      q.push_back(model());
      cyc(1);
      changeMin = 1'b0; min = 6'd30;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL trig_wait obs=%h exp=%h", obs, e); end
      m_ring = 1'b1; m_age = 0;
      q.push_back(model());
      cyc(1);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL trig_ring obs=%h exp=%h", obs, e); end
      m_age += 499; q.push_back(model()); cyc(499);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL beep_hold obs=%h exp=%h", obs, e); end
      m_age += 1; q.push_back(model()); cyc(1);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL beep_toggle obs=%h exp=%h", obs, e); end
      m_age += 500; q.push_back(model()); cyc(500);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL beep_toggle2 obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= 5; i++) begin
         changeMin = 1'b1;
         m_age += 1;
         if (i == 5) m_ring = 1'b0;
         q.push_back(model());
         cyc(1);
         changeMin = 1'b0; min = 6'(30 + i);
         e = q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL timeout%0d obs=%h exp=%h", i, obs, e); end
      end
      q.push_back(model());
      cyc(3);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL no_retrig obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_snooze();
      snooze = 1'b1;  // ignored while idle
      q.push_back(model()); cyc(1); snooze = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze_idle obs=%h exp=%h", obs, e); end
      ring_up();
      m_age += 10; cyc(10);
      snooze = 1'b1; m_ring = 1'b0; m_snz = 1'b1;
      q.push_back(model()); cyc(1); snooze = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze_enter obs=%h exp=%h", obs, e); end
      snooze = 1'b1;
      q.push_back(model()); cyc(1); snooze = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze_again obs=%h exp=%h", obs, e); end
      for (int i = 1; i <= 9; i++) begin
         changeMin = 1'b1;
         if (i == 9) begin m_ring = 1'b1; m_snz = 1'b0; m_age = 0; end
         q.push_back(model());
         cyc(1);
         changeMin = 1'b0; min = 6'(30 + i);
         e = q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL snooze_min%0d obs=%h exp=%h", i, obs, e); end
      end
   endtask

   task automatic test_priority();
      snooze = 1'b1; alarmEn = 1'b0; m_ring = 1'b0; m_snz = 1'b0;
      q.push_back(model()); cyc(1); snooze = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL en_over_snooze obs=%h exp=%h", obs, e); end
      min = 6'd29; cyc(1);
      changeMin = 1'b1; cyc(1);
      changeMin = 1'b0; min = 6'd30;
      q.push_back(model()); cyc(3);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL disarmed obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_reset_mid_ring();
      alarmEn = 1'b1;
      ring_up();
      m_age += 5; cyc(5);
      reset = 1'b1;
      m_ah = '0; m_am = '0; m_ring = 1'b0; m_snz = 1'b0; m_age = 0;
      q.push_back(model()); cyc(1);
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_ring obs=%h exp=%h", obs, e); end
   endtask

   task automatic test_btn_trigger();
      // alarm is 00:00 after reset; minute change lands on the first free cycle
      reset = 1'b0; hour = 5'd0; min = 6'd0; changeMin = 1'b1;
      q.push_back(model()); cyc(1); changeMin = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL post_reset obs=%h exp=%h", obs, e); end
      btnMin = 1'b1; m_am = 6'd1; m_ring = 1'b1; m_age = 0;
      q.push_back(model()); cyc(1); btnMin = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL btn_and_trig obs=%h exp=%h", obs, e); end
      btnHour = 1'b1; btnMin = 1'b1; m_age += 1;
      q.push_back(model()); cyc(1); btnHour = 1'b0; btnMin = 1'b0;
      e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL btn_in_ring obs=%h exp=%h", obs, e); end
   endtask

   initial begin
      reset = 1'b1; changeMin = 1'b0; alarmEn = 1'b0; btnHour = 1'b0;
      btnMin = 1'b0; snooze = 1'b0; hour = 5'd0; min = 6'd0;
      test_reset();
      test_buttons();
      test_ring();
      test_timeout();
      test_snooze();
      test_priority();
      test_reset_mid_ring();
      test_btn_trigger();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter SNOOZE_MIN, default 9, minutes spent in SNOOZE before re-ringing (1..63).
REQ-002 Parameter RING_MIN, default 5, minutes of RING before automatic stop (1..63).
REQ-003 Parameter BEEP_HALF, default 500, buzzer half-period in clkMSec cycles (>=2).
REQ-004 clkMSec  input  1  sole clock, 1 ms period; all state on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hour  input  5  current hour, 24-hour form, 0..23.
REQ-007 min  input  6  current minute, 0..59.
REQ-008 changeMin  input  1  one-cycle pulse; hour/min hold the new value from the following cycle.
REQ-009 alarmEn  input  1  level; 1 = alarm armed.
REQ-010 btnHour  input  1  one-cycle pulse; advance alarm hour.
REQ-011 btnMin  input  1  one-cycle pulse; advance alarm minute.
REQ-012 snooze  input  1  one-cycle pulse; snooze request.
REQ-013 alarmHour  output  5  stored alarm hour, 0..23.
REQ-014 alarmMin  output  6  stored alarm minute, 0..59.
REQ-015 ringing  output  1  high while state = RING.
REQ-016 snoozed  output  1  high while state = SNOOZE.
REQ-017 buzzer  output  1  square wave while RING, else 0.

Function
REQ-018 States IDLE, RING, SNOOZE; ringing/snoozed decode the state directly (registered).
REQ-019 Trigger = changeMin delayed one cycle AND hour==alarmHour AND min==alarmMin AND alarmEn; evaluated only in IDLE.
REQ-020 IDLE -> RING on trigger; ring-minute counter cleared to 0, beep counter cleared, buzzer 1 on first RING cycle.
REQ-021 In RING: beep counter counts 0..BEEP_HALF-1; buzzer toggles on the cycle the counter wraps.
REQ-022 In RING: each changeMin increments ring-minute counter; on reaching RING_MIN -> IDLE.
REQ-023 RING -> SNOOZE on snooze pulse; snooze counter cleared; buzzer 0 next cycle.
REQ-024 In SNOOZE: each changeMin increments snooze counter; on reaching SNOOZE_MIN -> RING with ring-minute and beep counters cleared, buzzer 1.
REQ-025 alarmEn = 0 in RING or SNOOZE -> IDLE next cycle; highest priority.
REQ-026 Priority in RING same cycle: alarmEn low > snooze > ring timeout.
REQ-027 snooze pulse in IDLE or SNOOZE ignored.
REQ-028 btnHour in IDLE: alarmHour = alarmHour+1, 23 wraps to 0; btnMin: alarmMin+1, 59 wraps to 0; no carry into hour.
REQ-029 btnHour/btnMin ignored in RING and SNOOZE.
REQ-030 Button and trigger in same cycle: trigger compares pre-update alarm value; update still applied.
REQ-031 Button edits never trigger; only the changeMin-qualified compare does.
REQ-032 Counters saturate-safe: widths sized for 63 minutes and BEEP_HALF; no wrap-induced false exit.

Reset
REQ-033 reset high at a clock edge: state IDLE, alarmHour 0, alarmMin 0, ringing 0, snoozed 0, buzzer 0, all counters 0.
REQ-034 reset overrides all inputs, including during RING or SNOOZE.
REQ-035 First trigger evaluation possible on the cycle after reset deasserts.

Verification
REQ-036 Reset, btnHour x7, btnMin x30 -> alarmHour 7, alarmMin 30; btnHour x17 more -> alarmHour 0.
REQ-037 alarmEn=1, alarm 07:30, hour/min step 07:29 -> 07:30 with changeMin -> ringing 1 two cycles after pulse; buzzer toggles every 500 cycles.
REQ-038 Ringing, no snooze, 5 changeMin pulses -> ringing 0, buzzer 0, state IDLE; no retrigger at 07:35.
REQ-039 Ringing, snooze pulse -> snoozed 1, buzzer 0; 9 changeMin pulses -> ringing 1 again, buzzer 1.
REQ-040 Ringing, snooze and alarmEn=0 same cycle -> IDLE, snoozed 0; alarmEn=0 at 07:30 minute change -> no ring.
REQ-041 reset asserted mid-RING with alarm 07:30 -> all outputs 0, alarmHour 0, alarmMin 0 next cycle.
